// File: rtl/serial_rx_param_if.sv
// Output side of the serial receiver: the received-word register with its
// valid/ready handshake, plus the three one-cycle error pulses.
// The receiver drives through 'master'; the consumer attaches to 'slave'.
interface serial_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    output parity_err,
    output frame_err,
    output overrun
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    input  parity_err,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/serial_rx_param.sv
// Parametrised LSB-first serial frame receiver.
// Frame: start(0), DATA_BITS data, optional parity bit, STOP_BITS stop bits (1).
// Every state change is gated by bit_en; the word register and the error
// pulses are registered and valid the cycle after the deciding sample.
module serial_rx_param #(
  parameter int DATA_BITS   = 8,  // 5..16
  parameter int PARITY_MODE = 1,  // 0 none, 1 odd, 2 even
  parameter int STOP_BITS   = 1   // 1 or 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_en,
  input  logic               in,
  serial_rx_param_if.master  rx
);

  localparam int CNT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DATA   = 3'd1;
  localparam logic [2:0] PARITY = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] RESYNC = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [CNT_W-1:0]     count;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  // Strobes produced by the STOP state on a sampled edge.
  logic done;      // last stop bit sampled as 1: frame complete
  logic stop_bad;  // any stop bit sampled as 0
  logic par_ok;
  logic accept;

  // Parity is computed over data plus the received parity bit; with no parity
  // configured every completed frame counts as good.
  always_comb begin
    par_ok = 1'b1;
    if (PARITY_MODE == 1)
      par_ok = (^{shreg, par_bit}) == 1'b1;
    else if (PARITY_MODE == 2)
      par_ok = (^{shreg, par_bit}) == 1'b0;
  end

  assign accept = rx.out_valid & rx.out_ready;

  // Next-state decode; nothing moves unless bit_en samples the line.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    stop_bad  = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!in)
            state_nxt = DATA;
        end
        DATA: begin
          if (count == LAST_BIT)
            state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
        end
        PARITY: begin
          state_nxt = STOP;
        end
        STOP: begin
          // A bad stop bit aborts at once, so with two stop bits a bad first
          // one never lets the second be examined.
          if (!in) begin
            stop_bad  = 1'b1;
            state_nxt = RESYNC;
          end else if (stop_cnt == LAST_STOP) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
        RESYNC: begin
          // Wait out a stuck-low line before hunting for a new start bit.
          if (in)
            state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Bit counters, data shift register and captured parity bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else if (bit_en) begin
      case (state)
        IDLE: begin
          count    <= '0;
          stop_cnt <= 1'b0;
        end
        DATA: begin
          shreg[count] <= in;
          count        <= count + 1'b1;
        end
        PARITY: begin
          par_bit <= in;
        end
        STOP: begin
          if (in)
            stop_cnt <= stop_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Output word register with valid/ready handshake and one-cycle error pulses.
  // A completing frame may load on the same edge the old word is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx.out_data   <= '0;
      rx.out_valid  <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
      if (accept)
        rx.out_valid <= 1'b0;
      if (stop_bad) begin
        rx.frame_err <= 1'b1;
      end else if (done) begin
        if (!par_ok) begin
          rx.parity_err <= 1'b1;
        end else if (!rx.out_valid || rx.out_ready) begin
          rx.out_data  <= shreg;
          rx.out_valid <= 1'b1;
        end else begin
          rx.overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_param.sv
// Bench for serial_rx_param: DUT 0 uses defaults (8 data, odd parity, 1 stop),
// DUT 1 uses 7 data, no parity, 2 stops. Frames are built from their data word
// and a reference model predicts the output register and error pulse counts.
module tb_serial_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2];
  logic ben [2];
  logic lin [2];

  serial_rx_param_if #(.DATA_BITS(8)) a_if ();
  serial_rx_param_if #(.DATA_BITS(7)) b_if ();

  serial_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(rst[0]), .bit_en(ben[0]), .in(lin[0]), .rx(a_if.master)
  );

  serial_rx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(rst[1]), .bit_en(ben[1]), .in(lin[1]), .rx(b_if.master)
  );

  int checks = 0;
  int errors = 0;

  // Observed pulse-cycle counts, sampled mid-cycle.
  int pe [2] = '{0, 0};
  int fe [2] = '{0, 0};
  int ov [2] = '{0, 0};

  always @(negedge clk) begin
    if (a_if.parity_err) pe[0] = pe[0] + 1;
    if (a_if.frame_err)  fe[0] = fe[0] + 1;
    if (a_if.overrun)    ov[0] = ov[0] + 1;
    if (b_if.parity_err) pe[1] = pe[1] + 1;
    if (b_if.frame_err)  fe[1] = fe[1] + 1;
    if (b_if.overrun)    ov[1] = ov[1] + 1;
  end

  // Reference model state.
  logic        exp_valid [2];
  logic [15:0] exp_data  [2];
  int          exp_pe    [2] = '{0, 0};
  int          exp_fe    [2] = '{0, 0};
  int          exp_ov    [2] = '{0, 0};

  function automatic logic get_valid(int d);
    return (d == 0) ? a_if.out_valid : b_if.out_valid;
  endfunction

  function automatic logic [15:0] get_data(int d);
    return (d == 0) ? {8'b0, a_if.out_data} : {9'b0, b_if.out_data};
  endfunction

  task automatic set_ready(int d, logic v);
    if (d == 0) a_if.out_ready = v;
    else        b_if.out_ready = v;
  endtask

  // One sampled bit: period-1 unstrobed cycles carrying junk, then the strobe.
  // ready, when requested, is raised only on the strobed cycle.
  task automatic put_bit(int d, logic b, int period, logic rdy);
    for (int k = 0; k < period - 1; k++) begin
      ben[d] = 1'b0;
      lin[d] = 1'($urandom);
      @(posedge clk); #1;
    end
    ben[d] = 1'b1;
    lin[d] = b;
    if (rdy) set_ready(d, 1'b1);
    @(posedge clk); #1;
    ben[d] = 1'b0;
    lin[d] = 1'b1;
    set_ready(d, 1'b0);
  endtask

  // Sends a frame and updates the model. bad_stop: -1 none, else index of the
  // stop bit forced to 0 (the frame is cut there). rdy_end raises out_ready on
  // the deciding edge.
  task automatic send_frame(int d, logic [15:0] data, logic bad_par,
                            int bad_stop, int period, logic rdy_end);
    int nb, pm, sb, ones;
    logic pbit, acc, last;
    nb = (d == 0) ? 8 : 7;
    pm = (d == 0) ? 1 : 0;
    sb = (d == 0) ? 1 : 2;
    ones = 0;
    put_bit(d, 1'b0, period, 1'b0);
    for (int i = 0; i < nb; i++) begin
      put_bit(d, data[i], period, 1'b0);
      if (data[i]) ones++;
    end
    if (pm != 0) begin
      pbit = (pm == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      put_bit(d, pbit ^ bad_par, period, 1'b0);
    end
    for (int s = 0; s < sb; s++) begin
      last = (s == sb - 1) || (s == bad_stop);
      put_bit(d, (s == bad_stop) ? 1'b0 : 1'b1, period, last && rdy_end);
      if (last) break;
    end
    acc = rdy_end && exp_valid[d];
    if (bad_stop >= 0) begin
      exp_fe[d]++;
      if (acc) exp_valid[d] = 1'b0;
    end else if (bad_par && pm != 0) begin
      exp_pe[d]++;
      if (acc) exp_valid[d] = 1'b0;
    end else if (!exp_valid[d] || rdy_end) begin
      exp_valid[d] = 1'b1;
      exp_data[d]  = data;
    end else begin
      exp_ov[d]++;
    end
  endtask

  task automatic pulse_ready(int d);
    set_ready(d, 1'b1);
    @(posedge clk); #1;
    set_ready(d, 1'b0);
    exp_valid[d] = 1'b0;
  endtask

  // Move past the negedge so pulses from the last edge have been counted.
  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ben[d] = 1'b0; lin[d] = 1'b1;
      exp_valid[d] = 1'b0; exp_data[d] = '0;
    end
    set_ready(0, 1'b0); set_ready(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    settle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get_valid(d) !== 1'b0) begin
        errors++; $display("FAIL reset_valid dut%0d: got %b want 0", d, get_valid(d));
      end
      checks++;
      if (get_data(d) !== 16'h0) begin
        errors++; $display("FAIL reset_data dut%0d: got %h want 0", d, get_data(d));
      end
    end
    checks++;
    if ({a_if.parity_err, a_if.frame_err, a_if.overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 000", {a_if.parity_err, a_if.frame_err, a_if.overrun});
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] v;
    v = 8'hA5;
    put_bit(0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(0, v[i], 1, 1'b0);
    put_bit(0, 1'b1, 1, 1'b0);
    checks++;
    if (a_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL good_early_valid: got %b want 0 at cycle 10", a_if.out_valid);
    end
    put_bit(0, 1'b1, 1, 1'b0);
    exp_valid[0] = 1'b1; exp_data[0] = 16'h00A5;
    checks++;
    if (a_if.out_valid !== 1'b1 || a_if.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL good_frame: got valid=%b data=%h want 1/a5", a_if.out_valid, a_if.out_data);
    end
    repeat (3) @(posedge clk);
    settle();
    checks++;
    if (a_if.out_valid !== 1'b1 || pe[0] != exp_pe[0] || fe[0] != exp_fe[0] || ov[0] != exp_ov[0]) begin
      errors++;
      $display("FAIL good_hold: got valid=%b pe=%0d fe=%0d ov=%0d want 1/%0d/%0d/%0d",
               a_if.out_valid, pe[0], fe[0], ov[0], exp_pe[0], exp_fe[0], exp_ov[0]);
    end
    pulse_ready(0);
    checks++;
    if (a_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL good_clear: got valid=%b want 0", a_if.out_valid);
    end
  endtask

  task automatic test_parity_err();
    send_frame(0, 16'h00A5, 1'b1, -1, 1, 1'b0);
    settle();
    checks++;
    if (pe[0] != exp_pe[0] || a_if.out_valid !== 1'b0 || ov[0] != exp_ov[0]) begin
      errors++;
      $display("FAIL parity_err: got pe=%0d valid=%b ov=%0d want %0d/0/%0d",
               pe[0], a_if.out_valid, ov[0], exp_pe[0], exp_ov[0]);
    end
  endtask

  task automatic test_frame_resync();
    send_frame(0, 16'h003C, 1'b0, 0, 1, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(0, 1'b0, 1, 1'b0);
    put_bit(0, 1'b1, 1, 1'b0);
    settle();
    checks++;
    if (fe[0] != exp_fe[0] || a_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_err: got fe=%0d valid=%b want %0d/0", fe[0], a_if.out_valid, exp_fe[0]);
    end
    send_frame(0, 16'h0081, 1'b0, -1, 1, 1'b0);
    settle();
    checks++;
    if (a_if.out_valid !== 1'b1 || a_if.out_data !== 8'h81 || pe[0] != exp_pe[0] || fe[0] != exp_fe[0]) begin
      errors++;
      $display("FAIL resync_frame: got valid=%b data=%h pe=%0d fe=%0d want 1/81/%0d/%0d",
               a_if.out_valid, a_if.out_data, pe[0], fe[0], exp_pe[0], exp_fe[0]);
    end
    pulse_ready(0);
  endtask

  task automatic test_back_to_back();
    send_frame(0, 16'h0011, 1'b0, -1, 1, 1'b0);
    send_frame(0, 16'h0022, 1'b0, -1, 1, 1'b0);
    settle();
    checks++;
    if (a_if.out_data !== 8'h11 || a_if.out_valid !== 1'b1 || ov[0] != exp_ov[0]) begin
      errors++;
      $display("FAIL back_to_back: got data=%h valid=%b ov=%0d want 11/1/%0d",
               a_if.out_data, a_if.out_valid, ov[0], exp_ov[0]);
    end
    pulse_ready(0);
    checks++;
    if (a_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_clear: got valid=%b want 0", a_if.out_valid);
    end
  endtask

  task automatic test_strobe_accept();
    send_frame(0, 16'h0011, 1'b0, -1, 3, 1'b0);
    send_frame(0, 16'h00A5, 1'b0, -1, 3, 1'b1);
    settle();
    checks++;
    if (a_if.out_data !== 8'hA5 || a_if.out_valid !== 1'b1 || ov[0] != exp_ov[0]) begin
      errors++;
      $display("FAIL strobe_accept: got data=%h valid=%b ov=%0d want a5/1/%0d",
               a_if.out_data, a_if.out_valid, ov[0], exp_ov[0]);
    end
    pulse_ready(0);
  endtask

  task automatic test_cfg_b();
    // Second stop bit low.
    send_frame(1, 16'h0041, 1'b0, 1, 1, 1'b0);
    put_bit(1, 1'b1, 1, 1'b0);
    settle();
    checks++;
    if (fe[1] != exp_fe[1] || b_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b_stop2_err: got fe=%0d valid=%b want %0d/0", fe[1], b_if.out_valid, exp_fe[1]);
    end
    // First stop bit low aborts immediately.
    send_frame(1, 16'h0055, 1'b0, 0, 1, 1'b0);
    put_bit(1, 1'b1, 1, 1'b0);
    send_frame(1, 16'h002A, 1'b0, -1, 1, 1'b0);
    settle();
    checks++;
    if (fe[1] != exp_fe[1] || b_if.out_valid !== 1'b1 || b_if.out_data !== 7'h2A) begin
      errors++;
      $display("FAIL b_stop1_err: got fe=%0d valid=%b data=%h want %0d/1/2a",
               fe[1], b_if.out_valid, b_if.out_data, exp_fe[1]);
    end
    pulse_ready(1);
    // Reset mid-data discards the partial frame.
    put_bit(1, 1'b0, 1, 1'b0);
    for (int i = 0; i < 3; i++) put_bit(1, 1'b1, 1, 1'b0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    for (int i = 0; i < 12; i++) put_bit(1, 1'b1, 1, 1'b0);
    settle();
    checks++;
    if (b_if.out_valid !== 1'b0 || fe[1] != exp_fe[1] || pe[1] != exp_pe[1] || ov[1] != exp_ov[1]) begin
      errors++;
      $display("FAIL b_mid_reset: got valid=%b fe=%0d pe=%0d ov=%0d want 0/%0d/%0d/%0d",
               b_if.out_valid, fe[1], pe[1], ov[1], exp_fe[1], exp_pe[1], exp_ov[1]);
    end
  endtask

  task automatic test_random(int d, int n);
    logic [15:0] data;
    int nb, sb, bs, gap;
    logic bp, re;
    nb = (d == 0) ? 8 : 7;
    sb = (d == 0) ? 1 : 2;
    for (int f = 0; f < n; f++) begin
      data = 16'($urandom) & 16'((1 << nb) - 1);
      bp   = ($urandom_range(0, 5) == 0);
      bs   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, sb - 1)) : -1;
      re   = ($urandom_range(0, 2) == 0);
      send_frame(d, data, bp, bs, int'($urandom_range(1, 3)), re);
      gap = int'($urandom_range(0, 2));
      if (bs >= 0 && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) put_bit(d, 1'b1, 1, 1'b0);
      settle();
      checks++;
      if (get_valid(d) !== exp_valid[d] || (exp_valid[d] && get_data(d) !== exp_data[d]) ||
          pe[d] != exp_pe[d] || fe[d] != exp_fe[d] || ov[d] != exp_ov[d]) begin
        errors++;
        $display("FAIL random dut%0d frame %0d: got v=%b d=%h pe=%0d fe=%0d ov=%0d want v=%b d=%h pe=%0d fe=%0d ov=%0d",
                 d, f, get_valid(d), get_data(d), pe[d], fe[d], ov[d],
                 exp_valid[d], exp_data[d], exp_pe[d], exp_fe[d], exp_ov[d]);
      end
      if ($urandom_range(0, 2) == 0 && exp_valid[d]) pulse_ready(d);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_resync();
    test_back_to_back();
    test_strobe_accept();
    test_cfg_b();
    test_random(0, 25);
    test_random(1, 25);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_param.md
# serial_rx_param

Parametrised serial frame receiver and successor to the fixed 8-bit, odd-parity, one-stop-bit receiver FSM. It deserialises LSB-first frames from the single-bit line `in`. Data width, parity mode and stop-bit count are configurable. Line samples are gated by a bit-rate strobe, and received words are delivered through a valid/ready output register. Parity, framing and overrun errors are reported as one-cycle pulses. The block sits between the line-sampling front end and the packet/byte consumer.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–16.
- `PARITY_MODE`, default 1: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2 stop bits.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `bit_en`  in  1  sample strobe; `in` is sampled only on edges where `bit_en`=1.
- `in`  in  1  serial line; idle high.
- `out_data`  out  DATA_BITS  received word; bit 0 is the first data bit on the line.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word when `out_valid` and `out_ready` are both 1.
- `parity_err`  out  1  one-cycle pulse: frame dropped because of a parity mismatch.
- `frame_err`  out  1  one-cycle pulse: a stop bit was sampled as 0.
- `overrun`  out  1  one-cycle pulse: a good frame was dropped because the output register was full.

## Operation
- States:
  - IDLE: sample 0 → DATA (start bit), bit counter = 0; sample 1 → stay.
  - DATA: shift sample into bit `count`, then increment `count`. After DATA_BITS samples → PARITY if `PARITY_MODE`≠0, otherwise → STOP.
  - PARITY: capture the parity bit, then → STOP.
  - STOP: sample 1 → if this is the last stop bit, complete the frame and → IDLE; otherwise stay for the second stop bit. Sample 0 → assert `frame_err` and → RESYNC.
  - RESYNC: sample 1 → IDLE; sample 0 → stay.
- All transitions happen only on edges where `bit_en`=1. When `bit_en`=0, state, counters and the shift register hold.
- Parity check (over the data bits plus the parity bit):
  - Odd mode: the count of ones must be odd.
  - Even mode: the count of ones must be even.
- On frame completion with no error:
  - If the output register is empty, or is being accepted on the same edge, load `out_data` and set `out_valid`=1.
  - Otherwise keep the old word, leave `out_valid`=1, and pulse `overrun`.
- A parity mismatch on a completed frame pulses `parity_err`, produces no output and never causes `overrun`.
- Error precedence: a bad stop bit reports `frame_err` only, regardless of parity.
- With STOP_BITS=2, a bad first stop bit aborts the frame immediately; the second stop bit is not examined.
- `out_valid` clears on the edge where `out_valid`=1 and `out_ready`=1, unless a new word loads on that same edge.
- Back-to-back frames: a 0 sampled in IDLE directly after the last stop bit is a valid start bit. No idle gap is required.
- Reset:
  - state = IDLE; counters = 0.
  - `out_data`=0, `out_valid`=0, all error outputs = 0.
  - A reset mid-frame discards the partial frame and produces no output or error pulse.

## Timing
- Frame length in sampled bits: 1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS.
- With `bit_en`=1 continuously, the start bit is sampled at edge 0 and the last stop bit at edge L−1, where L is the frame length.
- `out_valid`, `parity_err`, `frame_err` and `overrun` are registered. Each asserts in the cycle after the edge that sampled the deciding bit.
- Error pulses are exactly one `clk` cycle wide, independent of `bit_en`.
- Timing of the deciding edge per output:
  - `out_valid`, `parity_err`, `overrun`: the last stop-bit sample.
  - `frame_err`: the failing stop-bit sample.
- `out_ready` is not required to be registered by the consumer. Acceptance takes effect on the same edge.

## Test plan
- **Default parameters, good frame, `out_ready`=0.** Stimulus: start 0; data bits 1,0,1,0,0,1,0,1 (0xA5); parity bit 1; stop 1. Required: `out_data`=0xA5 and `out_valid`=1 from cycle 11 onward; no error pulses.
- **Parity error.** Stimulus: same frame with parity bit 0. Required: `parity_err` high for exactly one cycle; `out_valid` stays 0.
- **Framing error and resync.** Stimulus: frame 0x3C with stop bit 0, then 4 samples of 0, then 1, then a good frame 0x81. Required: one `frame_err` pulse; no frame starts during the 0 samples; then `out_data`=0x81.
- **Back-to-back frames, `out_ready` held 0.** Stimulus: 0x11 then 0x22. Required: `out_data` stays 0x11 and `overrun` pulses once. Then a single-cycle `out_ready`=1 clears `out_valid`.
- **Strobe gating and simultaneous accept.** Stimulus: `bit_en` high every third cycle with frame 0xA5, and `out_ready`=1 on the completion edge while 0x11 is pending. Required: 0xA5 loads, `out_valid` stays 1, no `overrun`.
- **DATA_BITS=7, PARITY_MODE=0, STOP_BITS=2.** Stimulus: frame 0x41 with second stop bit 0 → `frame_err`. Separately, assert reset mid-data on a later frame. Required: `out_valid`=0 and no pulses afterwards.
